// File: rtl/hazard_flush_ctrl.sv
// Hazard / flush control for the IF-ID-EX front end.
// Tracks the instructions in EX and MEM with a two-slot shadow scoreboard,
// detects RAW hazards against ID, turns taken branches into flushes and
// freezes the back half of the pipe while memory inserts wait states.
module hazard_flush_ctrl #(
  parameter int REG_W      = 5,
  parameter bit FORWARD_EN = 1'b1,
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_valid,
  input  logic             id_wb_en,
  input  logic             id_mem_read,
  input  logic [REG_W-1:0] id_dst,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_freeze,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1
  } state_e;

  // Wait counter is wide enough to hold TIMEOUT-1 and saturates there.
  localparam int WAIT_W = $clog2(TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  // EX shadow slot
  logic             ex_valid_q,    ex_valid_d;
  logic             ex_wb_en_q,    ex_wb_en_d;
  logic             ex_mem_read_q, ex_mem_read_d;
  logic [REG_W-1:0] ex_dst_q,      ex_dst_d;

  // MEM shadow slot
  logic             mem_valid_q,   mem_valid_d;
  logic             mem_wb_en_q,   mem_wb_en_d;
  logic [REG_W-1:0] mem_dst_q,     mem_dst_d;

  // Wait-state FSM and statistics
  state_e           state_q,       state_d;
  logic [WAIT_W-1:0] wait_cnt_q,   wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  // Combinational control terms
  logic match_ex;
  logic match_mem;
  logic hazard;
  logic issue;
  logic mem_stall;

  // Source-vs-destination comparison against each in-flight slot.
  always_comb begin
    match_ex  = ex_valid_q & ex_wb_en_q &
                ((id_src1 == ex_dst_q) | (id_two_src & (id_src2 == ex_dst_q)));
    match_mem = mem_valid_q & mem_wb_en_q &
                ((id_src1 == mem_dst_q) | (id_two_src & (id_src2 == mem_dst_q)));
  end

  // With forwarding only a load in EX cannot supply its result in time;
  // without it, any producer still in EX or MEM blocks the reader.
  always_comb begin
    hazard = 1'b0;
    if (FORWARD_EN) begin
      hazard = id_valid & match_ex & ex_mem_read_q;
    end else begin
      hazard = id_valid & (match_ex | match_mem);
    end
  end

  // Freeze > branch flush > hazard stall; all outputs are zero-latency.
  always_comb begin
    mem_stall    = mem_req & ~mem_ready;
    pipe_freeze  = mem_stall;
    if_id_flush  = ex_branch_taken & ~mem_stall;
    id_ex_flush  = ~mem_stall & (ex_branch_taken | hazard);
    pc_freeze    = mem_stall | (hazard & ~ex_branch_taken);
    if_id_freeze = pc_freeze;
    issue        = id_valid & ~hazard & ~ex_branch_taken & ~mem_stall;
  end

  // Scoreboard advance: slots shift with the pipe and hold during a freeze.
  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_wb_en_d    = ex_wb_en_q;
    ex_mem_read_d = ex_mem_read_q;
    ex_dst_d      = ex_dst_q;
    mem_valid_d   = mem_valid_q;
    mem_wb_en_d   = mem_wb_en_q;
    mem_dst_d     = mem_dst_q;
    if (!mem_stall) begin
      mem_valid_d = ex_valid_q;
      mem_wb_en_d = ex_wb_en_q;
      mem_dst_d   = ex_dst_q;
      ex_valid_d  = issue;
      if (issue) begin
        ex_wb_en_d    = id_wb_en;
        ex_mem_read_d = id_mem_read;
        ex_dst_d      = id_dst;
      end
    end
  end

  // Wait-state FSM with saturating wait counter and sticky timeout flag.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready | ~mem_req) begin
          state_d = ST_RUN;
        end
        if (wait_cnt_q != WAIT_LAST) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if (mem_stall && (wait_cnt_q == WAIT_LAST)) begin
          mem_timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Stall statistics: count frozen-PC cycles, stick at all-ones.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (pc_freeze && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  // State registers; reset empties the scoreboard so no stale hazard survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_wb_en_q     <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_dst_q       <= '0;
      mem_valid_q    <= 1'b0;
      mem_wb_en_q    <= 1'b0;
      mem_dst_q      <= '0;
      state_q        <= ST_RUN;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_wb_en_q     <= ex_wb_en_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_dst_q       <= ex_dst_d;
      mem_valid_q    <= mem_valid_d;
      mem_wb_en_q    <= mem_wb_en_d;
      mem_dst_q      <= mem_dst_d;
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign state        = state_q;
  assign stall_cycles = stall_cycles_q;
  assign mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed bench for hazard_flush_ctrl. Two instances share the inputs:
// dut_fw has forwarding (FORWARD_EN=1, 32-bit counter), dut_nf has none
// (FORWARD_EN=0, 3-bit counter so saturation is reachable). TIMEOUT=4 on both.
// Control vectors are {pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, pipe_freeze}.
module tb_hazard_flush_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_src1, id_src2, id_dst;
  logic       id_two_src, id_valid, id_wb_en, id_mem_read;
  logic       ex_branch_taken, mem_req, mem_ready;

  logic        fw_pc_freeze, fw_if_id_freeze, fw_if_id_flush, fw_id_ex_flush, fw_pipe_freeze;
  logic [1:0]  fw_state;
  logic [31:0] fw_stall;
  logic        fw_timeout;

  logic        nf_pc_freeze, nf_if_id_freeze, nf_if_id_flush, nf_id_ex_flush, nf_pipe_freeze;
  logic [1:0]  nf_state;
  logic [2:0]  nf_stall;
  logic        nf_timeout;

  logic [4:0] fw_ctrl, nf_ctrl;
  assign fw_ctrl = {fw_pc_freeze, fw_if_id_freeze, fw_if_id_flush, fw_id_ex_flush, fw_pipe_freeze};
  assign nf_ctrl = {nf_pc_freeze, nf_if_id_freeze, nf_if_id_flush, nf_id_ex_flush, nf_pipe_freeze};

  int pass_cnt  = 0;
  int total_cnt = 0;

  hazard_flush_ctrl #(.REG_W(5), .FORWARD_EN(1'b1), .CNT_W(32), .TIMEOUT(4)) dut_fw (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_valid(id_valid), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_dst(id_dst),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_freeze(fw_pc_freeze), .if_id_freeze(fw_if_id_freeze), .if_id_flush(fw_if_id_flush),
    .id_ex_flush(fw_id_ex_flush), .pipe_freeze(fw_pipe_freeze), .state(fw_state),
    .stall_cycles(fw_stall), .mem_timeout(fw_timeout)
  );

  hazard_flush_ctrl #(.REG_W(5), .FORWARD_EN(1'b0), .CNT_W(3), .TIMEOUT(4)) dut_nf (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_valid(id_valid), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_dst(id_dst),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_freeze(nf_pc_freeze), .if_id_freeze(nf_if_id_freeze), .if_id_flush(nf_if_id_flush),
    .id_ex_flush(nf_id_ex_flush), .pipe_freeze(nf_pipe_freeze), .state(nf_state),
    .stall_cycles(nf_stall), .mem_timeout(nf_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #2;
  endtask

  task automatic set_id(input logic v, input logic wb, input logic mr, input logic [4:0] dst,
                        input logic [4:0] s1, input logic [4:0] s2, input logic two);
    id_valid = v; id_wb_en = wb; id_mem_read = mr; id_dst = dst;
    id_src1 = s1; id_src2 = s2; id_two_src = two;
  endtask

  task automatic idle();
    set_id(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    settle();
    total_cnt++;
    if ({fw_ctrl, fw_state, fw_timeout} !== 8'd0) $display("FAIL reset_fw_ctrl got ctrl=%b state=%0d to=%b want 0", fw_ctrl, fw_state, fw_timeout);
    else pass_cnt++;
    total_cnt++;
    if (fw_stall !== 32'd0 || nf_stall !== 3'd0) $display("FAIL reset_stall got fw=%0d nf=%0d want 0", fw_stall, nf_stall);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    settle();
    total_cnt++;
    if ({nf_ctrl, nf_state, nf_timeout} !== 8'd0) $display("FAIL reset_nf_ctrl got ctrl=%b state=%0d to=%b want 0", nf_ctrl, nf_state, nf_timeout);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0);   // load r5
    settle();
    total_cnt++;
    if (fw_ctrl !== 5'b00000) $display("FAIL loaduse_issue got %b want 00000", fw_ctrl);
    else pass_cnt++;
    tick();
    set_id(1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd0, 1'b0);   // reads r5
    settle();
    total_cnt++;
    if (fw_ctrl !== 5'b11010) $display("FAIL loaduse_stall got %b want 11010", fw_ctrl);
    else pass_cnt++;
    tick();
    settle();
    total_cnt++;
    if (fw_ctrl !== 5'b00000) $display("FAIL loaduse_release got %b want 00000", fw_ctrl);
    else pass_cnt++;
    total_cnt++;
    if (fw_stall !== 32'd1) $display("FAIL loaduse_count got %0d want 1", fw_stall);
    else pass_cnt++;
    tick();
    idle();
    settle();
    total_cnt++;
    if (fw_stall !== 32'd1) $display("FAIL loaduse_count_after got %0d want 1", fw_stall);
    else pass_cnt++;
  endtask

  task automatic test_alu_raw();
    do_reset();
    set_id(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0);   // ALU writes r3
    tick();
    set_id(1'b1, 1'b1, 1'b0, 5'd4, 5'd1, 5'd3, 1'b1);   // reads r3 via src2
    settle();
    total_cnt++;
    if (fw_ctrl !== 5'b00000) $display("FAIL alu_fw_nostall got %b want 00000", fw_ctrl);
    else pass_cnt++;
    total_cnt++;
    if (nf_ctrl !== 5'b11010) $display("FAIL alu_nf_ex_stall got %b want 11010", nf_ctrl);
    else pass_cnt++;
    tick();
    settle();
    total_cnt++;
    if (nf_ctrl !== 5'b11010) $display("FAIL alu_nf_mem_stall got %b want 11010", nf_ctrl);
    else pass_cnt++;
    tick();
    settle();
    total_cnt++;
    if (nf_ctrl !== 5'b00000) $display("FAIL alu_nf_release got %b want 00000", nf_ctrl);
    else pass_cnt++;
    tick();
    idle();
    settle();
    total_cnt++;
    if (nf_stall !== 3'd2 || fw_stall !== 32'd0) $display("FAIL alu_counts got nf=%0d fw=%0d want nf=2 fw=0", nf_stall, fw_stall);
    else pass_cnt++;
    // src2 match ignored when the instruction has only one source
    do_reset();
    set_id(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0);
    tick();
    set_id(1'b1, 1'b1, 1'b0, 5'd4, 5'd1, 5'd3, 1'b0);
    settle();
    total_cnt++;
    if (nf_ctrl !== 5'b00000) $display("FAIL alu_nf_one_src got %b want 00000", nf_ctrl);
    else pass_cnt++;
    tick();
    idle();
  endtask

  task automatic test_branch_hazard();
    do_reset();
    set_id(1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0);   // load r5
    tick();
    set_id(1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);   // dependent load r5
    ex_branch_taken = 1'b1;
    settle();
    total_cnt++;
    if (fw_ctrl !== 5'b00110) $display("FAIL branch_fw_flush got %b want 00110", fw_ctrl);
    else pass_cnt++;
    total_cnt++;
    if (nf_ctrl !== 5'b00110) $display("FAIL branch_nf_flush got %b want 00110", nf_ctrl);
    else pass_cnt++;
    tick();
    ex_branch_taken = 1'b0;
    settle();
    total_cnt++;
    if (fw_ctrl !== 5'b00000) $display("FAIL branch_ex_cleared got %b want 00000", fw_ctrl);
    else pass_cnt++;
    tick();
    idle();
  endtask

  task automatic test_mem_wait();
    logic [1:0] exp_state [3];
    exp_state[0] = 2'd0; exp_state[1] = 2'd1; exp_state[2] = 2'd1;
    do_reset();
    set_id(1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0);   // load r5 into EX slot
    tick();
    set_id(1'b1, 1'b1, 1'b0, 5'd7, 5'd5, 5'd0, 1'b0);
    mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      total_cnt++;
      if (fw_ctrl !== 5'b11001 || fw_state !== exp_state[i])
        $display("FAIL memwait_cyc%0d got ctrl=%b state=%0d want 11001 state=%0d", i, fw_ctrl, fw_state, exp_state[i]);
      else pass_cnt++;
      tick();
    end
    mem_ready = 1'b1; ex_branch_taken = 1'b0;
    settle();
    total_cnt++;
    if (fw_ctrl !== 5'b11010 || fw_state !== 2'd1)
      $display("FAIL memwait_ready got ctrl=%b state=%0d want 11010 state=1", fw_ctrl, fw_state);
    else pass_cnt++;
    tick();
    idle();
    settle();
    total_cnt++;
    if (fw_state !== 2'd0 || fw_stall !== 32'd4 || fw_timeout !== 1'b0)
      $display("FAIL memwait_done got state=%0d stall=%0d to=%b want 0/4/0", fw_state, fw_stall, fw_timeout);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      settle();
      total_cnt++;
      if (fw_timeout !== (c >= 6))
        $display("FAIL timeout_cyc%0d got %b want %b", c, fw_timeout, (c >= 6));
      else pass_cnt++;
      tick();
    end
    mem_ready = 1'b1;
    tick();
    idle();
    settle();
    total_cnt++;
    if (fw_timeout !== 1'b1 || fw_state !== 2'd0)
      $display("FAIL timeout_sticky got to=%b state=%0d want 1/0", fw_timeout, fw_state);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_reset();
    set_id(1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0);   // load r5
    tick();
    idle();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    settle();
    total_cnt++;
    if (fw_stall !== 32'd7 || nf_stall !== 3'd7 || fw_state !== 2'd1 || fw_timeout !== 1'b1)
      $display("FAIL prereset got fw=%0d nf=%0d state=%0d to=%b want 7/7/1/1", fw_stall, nf_stall, fw_state, fw_timeout);
    else pass_cnt++;
    tick();
    settle();
    total_cnt++;
    if (fw_stall !== 32'd8 || nf_stall !== 3'd7)
      $display("FAIL stall_saturate got fw=%0d nf=%0d want 8/7", fw_stall, nf_stall);
    else pass_cnt++;
    // pulse reset between edges
    rst = 1'b1;
    #1;
    total_cnt++;
    if (fw_state !== 2'd0 || fw_stall !== 32'd0 || fw_timeout !== 1'b0 || nf_stall !== 3'd0)
      $display("FAIL async_reset got state=%0d fw=%0d to=%b nf=%0d want 0/0/0/0", fw_state, fw_stall, fw_timeout, nf_stall);
    else pass_cnt++;
    #1;
    rst = 1'b0;
    mem_req = 1'b0;
    set_id(1'b1, 1'b1, 1'b0, 5'd8, 5'd5, 5'd0, 1'b0);
    #1;
    total_cnt++;
    if (fw_ctrl !== 5'b00000 || nf_ctrl !== 5'b00000)
      $display("FAIL post_reset_hazard got fw=%b nf=%b want 00000", fw_ctrl, nf_ctrl);
    else pass_cnt++;
    tick();
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_raw();
    test_branch_hazard();
    test_mem_wait();
    test_timeout();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
